// File: rtl/mux_arb_pkg.sv
// Shared types and source encodings for the two-source round-robin arbiter.
package mux_arb_pkg;

    typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} arb_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    function automatic arb_state_t grant_of(logic sel);
        return (sel == SEL_B) ? GRANT_B : GRANT_A;
    endfunction

endpackage

// File: rtl/mux_2_1_arb_if.sv
// Two valid/ready source streams, the merged output stream and the mux select.
interface mux_2_1_arb_if #(
    parameter int W = 8
);
    logic         a_valid;
    logic         a_ready;
    logic [W-1:0] a_data;
    logic         b_valid;
    logic         b_ready;
    logic [W-1:0] b_data;
    logic         s;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport slave (
        input  a_valid, a_data, b_valid, b_data, out_ready,
        output a_ready, b_ready, s, out_valid, out_data
    );

    modport master (
        output a_valid, a_data, b_valid, b_data, out_ready,
        input  a_ready, b_ready, s, out_valid, out_data
    );
endinterface

// File: rtl/mux_2_1.sv
// Single-bit 2:1 multiplexer: f = s ? b : a.
module mux_2_1 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic f
);
    assign f = s ? b : a;
endmodule

// File: rtl/mux_2_1_arb.sv
// Round-robin arbiter driving the select of a bit-sliced 2:1 mux and registering
// the chosen word onto one valid/ready stream, with bursts capped at HOLD_MAX.
module mux_2_1_arb
    import mux_arb_pkg::*;
#(
    parameter int W        = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    mux_2_1_arb_if.slave bus
);

    localparam int                RUN_W    = $clog2(HOLD_MAX + 1);
    localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(HOLD_MAX - 1);

    arb_state_t       state, state_nxt;
    logic             last, last_nxt;
    logic [RUN_W-1:0] run, run_nxt;
    logic             s_q, s_nxt;
    logic             out_valid_q;
    logic [W-1:0]     out_data_q;
    logic [W-1:0]     mux_f;

    logic slot_free;
    logic a_ready, b_ready;
    logic a_fire, b_fire, take;
    logic cur_sel, cur_valid, cur_fire, oth_valid;

    // Readies depend only on grant state and the output slot, never on source valids.
    assign slot_free = !out_valid_q || bus.out_ready;
    assign a_ready   = (state == GRANT_A) && slot_free;
    assign b_ready   = (state == GRANT_B) && slot_free;
    assign a_fire    = bus.a_valid && a_ready;
    assign b_fire    = bus.b_valid && b_ready;
    assign take      = a_fire || b_fire;

    assign cur_sel   = (state == GRANT_B) ? SEL_B : SEL_A;
    assign cur_valid = (cur_sel == SEL_B) ? bus.b_valid : bus.a_valid;
    assign cur_fire  = (cur_sel == SEL_B) ? b_fire : a_fire;
    assign oth_valid = (cur_sel == SEL_B) ? bus.a_valid : bus.b_valid;

    for (genvar i = 0; i < W; i++) begin : g_mux
        mux_2_1 u_mux (
            .a (bus.a_data[i]),
            .b (bus.b_data[i]),
            .s (s_q),
            .f (mux_f[i])
        );
    end

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        run_nxt   = run;
        unique case (state)
            IDLE: begin
                run_nxt = '0;
                if (bus.a_valid && bus.b_valid) begin
                    state_nxt = grant_of(~last);
                end else if (bus.a_valid) begin
                    state_nxt = GRANT_A;
                end else if (bus.b_valid) begin
                    state_nxt = GRANT_B;
                end
            end
            GRANT_A, GRANT_B: begin
                if (!cur_valid) begin
                    last_nxt  = cur_sel;
                    run_nxt   = '0;
                    state_nxt = oth_valid ? grant_of(~cur_sel) : IDLE;
                end else if (cur_fire && run == RUN_LAST) begin
                    // Burst cap: yield only if the other side is waiting.
                    run_nxt = '0;
                    if (oth_valid) begin
                        last_nxt  = cur_sel;
                        state_nxt = grant_of(~cur_sel);
                    end
                end else if (cur_fire) begin
                    run_nxt = run + RUN_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_nxt = s_q;
        case (state_nxt)
            GRANT_A: s_nxt = SEL_A;
            GRANT_B: s_nxt = SEL_B;
            default: s_nxt = s_q;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= SEL_B;
            run   <= '0;
            s_q   <= SEL_A;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            run   <= run_nxt;
            s_q   <= s_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (take) begin
            out_valid_q <= 1'b1;
            out_data_q  <= mux_f;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.a_ready   = a_ready;
    assign bus.b_ready   = b_ready;
    assign bus.s         = s_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_mux_2_1_arb.sv
// Directed bench for mux_2_1_arb: reset, single-source stream, contention with
// burst cap, output stall, drop-to-idle and asynchronous reset mid-burst.
module tb_mux_2_1_arb;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mux_2_1_arb_if #(.W(8)) bus ();

    mux_2_1_arb #(.W(8), .HOLD_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];

    logic [7:0] t2_data [13];
    logic       t2_s    [13];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_src();
        bus.a_valid = (qa.size() > 0);
        bus.a_data  = (qa.size() > 0) ? qa[0] : 8'h00;
        bus.b_valid = (qb.size() > 0);
        bus.b_data  = (qb.size() > 0) ? qb[0] : 8'h00;
    endtask

    // One clock: note which source handshakes, take the edge, pop and re-drive.
    task automatic step();
        logic acc_a, acc_b;
        #1;
        acc_a = bus.a_valid && bus.a_ready;
        acc_b = bus.b_valid && bus.b_ready;
        @(posedge clk);
        #1;
        if (acc_a) void'(qa.pop_front());
        if (acc_b) void'(qb.pop_front());
        drive_src();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        qa.delete();
        qb.delete();
        drive_src();
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        t2_data = '{8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
                    8'hA4, 8'hA5, 8'hA6, 8'hA7};
        t2_s    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset values
        do_reset();
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_out_data",  32'(bus.out_data),  32'h0);
        check("rst_s",         32'(bus.s),         32'h0);
        check("rst_a_ready",   32'(bus.a_ready),   32'h0);
        check("rst_b_ready",   32'(bus.b_ready),   32'h0);

        // Single source A stream
        qa = '{8'h11, 8'h12, 8'h13};
        drive_src();
        step();
        check("t1_entry_a_ready",   32'(bus.a_ready),   32'h1);
        check("t1_entry_out_valid", 32'(bus.out_valid), 32'h0);
        check("t1_entry_s",         32'(bus.s),         32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("t1_data%0d", k),  32'(bus.out_data),  32'(8'h11 + k));
            check($sformatf("t1_valid%0d", k), 32'(bus.out_valid), 32'h1);
        end
        step();
        check("t1_idle_out_valid", 32'(bus.out_valid), 32'h0);
        check("t1_idle_a_ready",   32'(bus.a_ready),   32'h0);

        // Contention with burst cap of 4, A wins first
        do_reset();
        for (int k = 0; k < 8; k++) begin
            qa.push_back(8'hA0 + 8'(k));
            qb.push_back(8'hB0 + 8'(k));
        end
        drive_src();
        for (int k = 0; k < 13; k++) begin
            step();
            check($sformatf("t2_s_e%0d", k + 1), 32'(bus.s), 32'(t2_s[k]));
            if (k > 0) begin
                check($sformatf("t2_data_e%0d", k + 1), 32'(bus.out_data), 32'(t2_data[k]));
                check($sformatf("t2_valid_e%0d", k + 1), 32'(bus.out_valid), 32'h1);
            end
        end

        // Output stall for 3 cycles, then resume from B4
        bus.out_ready = 1'b0;
        #1;
        check("t3_stall_a_ready", 32'(bus.a_ready), 32'h0);
        check("t3_stall_b_ready", 32'(bus.b_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("t3_frozen%0d", k),  32'(bus.out_data),  32'hA7);
            check($sformatf("t3_valid%0d", k),   32'(bus.out_valid), 32'h1);
            check($sformatf("t3_b_ready%0d", k), 32'(bus.b_ready),   32'h0);
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("t3_resume%0d", k), 32'(bus.out_data),  32'(8'hB4 + k));
            check($sformatf("t3_rvalid%0d", k), 32'(bus.out_valid), 32'h1);
        end
        step();
        check("t3_drained_valid", 32'(bus.out_valid), 32'h0);

        // B drops after 2 words: idle with s held at 1, then A alone
        qb = '{8'hC0, 8'hC1};
        drive_src();
        step();
        check("t4_grant_b_s", 32'(bus.s), 32'h1);
        step();
        check("t4_c0", 32'(bus.out_data), 32'hC0);
        step();
        check("t4_c1", 32'(bus.out_data), 32'hC1);
        step();
        check("t4_idle_s",       32'(bus.s),         32'h1);
        check("t4_idle_b_ready", 32'(bus.b_ready),   32'h0);
        check("t4_idle_valid",   32'(bus.out_valid), 32'h0);
        step();
        check("t4_idle_s_hold", 32'(bus.s), 32'h1);
        qa = '{8'hD0};
        drive_src();
        step();
        check("t4_grant_a_s",     32'(bus.s),       32'h0);
        check("t4_grant_a_ready", 32'(bus.a_ready), 32'h1);
        step();
        check("t4_d0", 32'(bus.out_data), 32'hD0);
        step();

        // Asynchronous reset in the middle of a B burst (last is A here)
        qb = '{8'hE0, 8'hE1, 8'hE2, 8'hE3};
        drive_src();
        step();
        step();
        step();
        check("t5_pre_data",  32'(bus.out_data),  32'hE1);
        check("t5_pre_valid", 32'(bus.out_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_valid",   32'(bus.out_valid), 32'h0);
        check("t5_async_data",    32'(bus.out_data),  32'h0);
        check("t5_async_s",       32'(bus.s),         32'h0);
        check("t5_async_b_ready", 32'(bus.b_ready),   32'h0);
        do_reset();
        qa = '{8'hF0};
        qb = '{8'hF8};
        drive_src();
        step();
        check("t5_first_s",       32'(bus.s),       32'h0);
        check("t5_first_a_ready", 32'(bus.a_ready), 32'h1);
        check("t5_first_b_ready", 32'(bus.b_ready), 32'h0);
        step();
        check("t5_f0", 32'(bus.out_data), 32'hF0);
        step();
        check("t5_switch_s", 32'(bus.s), 32'h1);
        step();
        check("t5_f8", 32'(bus.out_data), 32'hF8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_2_1_arb.md
# mux_2_1_arb

Round-robin two-source arbiter that generates the select line for the `mux_2_1` datapath and registers the selected word onto a single valid/ready output stream. It sits directly upstream of, and wraps, the 2:1 mux. It converts two independent request streams into one ordered stream, with bounded burst length per source.

## Interface
- `W`, 8: data width of each source and of the output.
- `HOLD_MAX`, 4: maximum consecutive transfers from one source while the other is requesting; legal range ≥ 1.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `a_valid` input 1: source A has a word.
- `a_ready` output 1: A word accepted this cycle when `a_valid & a_ready`.
- `a_data` input W: source A word; selected when `s=0`.
- `b_valid` input 1: source B has a word.
- `b_ready` output 1: B word accepted this cycle when `b_valid & b_ready`.
- `b_data` input W: source B word; selected when `s=1`.
- `s` output 1: registered mux select (0=A, 1=B), equal to the current grant.
- `out_valid` output 1: output register holds a word.
- `out_ready` input 1: downstream accepts the word.
- `out_data` output W: registered selected word.

## Operation
- FSM states: IDLE, GRANT_A, GRANT_B. `last` records the last granted source. `run` counts transfers in the current grant.
  - `run` width is `$clog2(HOLD_MAX+1)`.
- IDLE:
  - Only A valid: go to GRANT_A.
  - Only B valid: go to GRANT_B.
  - Both valid: grant the source ≠ `last`.
  - Neither valid: stay in IDLE.
  - No transfer is accepted in IDLE.
- GRANT_x:
  - `x_ready = !out_valid | out_ready`; the other ready is 0.
  - Each accepted word increments `run`.
- Leaving GRANT_x, evaluated on the edge after each cycle:
  - If `x_valid` is low and the other source is valid: switch to the other grant. Set `run=0`, `last=x`.
  - If `x_valid` is low and the other source is not valid: go to IDLE and set `last=x`.
  - If `run` reaches HOLD_MAX on this edge's transfer and the other source is valid: switch to the other grant and set `run=0`.
  - If `run` reaches HOLD_MAX and the other source is not valid: stay in GRANT_x and set `run=0`.
- `s` is 1 in GRANT_B. It holds its previous value in IDLE.
- Output register:
  - Loads the mux output (`s ? b_data : a_data`) on any accepted transfer and sets `out_valid`.
  - Clears `out_valid` on `out_ready` with no new load.
  - Simultaneous drain and load keeps `out_valid=1` with the new word.
- `out_data` is unchanged while `out_valid & !out_ready` (stall). Source readies are 0 during a stall.

## Timing
- Reset values: state IDLE, `s=0`, `out_valid=0`, `out_data=0`, `last=B`, `run=0`, `a_ready=b_ready=0`.
  - `last=B` means A wins the first contention.
- Reset asserted mid-burst aborts immediately. The word in the output register is discarded.
- Entering a grant from IDLE costs 1 cycle. A source switch between grants has no idle cycle: the new source is ready on the cycle after the switch edge.
- Latency: a word accepted at edge N is on `out_data` with `out_valid=1` after edge N. It is consumed at the first edge ≥ N+1 with `out_ready=1`.
- Throughput: 1 word/cycle with `out_ready` held high.
- Source readies are combinational from `out_ready` and state only, never from `a_valid`/`b_valid`.
- Source handshake rule: once `x_valid` is asserted, data is held stable until accepted.

## Structure
- Shared package `mux_arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} arb_state_t`.
  - Source encoding constants `SEL_A=1'b0`, `SEL_B=1'b1`.
- Datapath: `W` instances of the existing `mux_2_1` (ports a, b, s, f) in a generate loop, driven by registered `s`. The arbiter FSM, counter and output register live in `mux_2_1_arb`.

## Test plan
- Reset, then `a_valid=1` only with `a_data` 0x11,0x12,0x13 and `out_ready=1` -> IDLE→GRANT_A after 1 cycle, `s=0`, `out_data` 0x11,0x12,0x13 on consecutive cycles, no forced switch.
- Both sources valid continuously, HOLD_MAX=4, `out_ready=1` -> output order A×4, B×4, A×4; `s` toggles with no bubble; A first.
- `out_ready=0` for 3 cycles with `out_valid=1` -> `out_data` frozen, `a_ready=b_ready=0`. On release, one word per cycle resumes with none lost or duplicated.
- GRANT_B, `b_valid` drops after 2 words while `a_valid=0` -> IDLE, `s` stays 1. A later arrives alone -> GRANT_A with `s=0`.
- `rst_n` pulsed low mid-burst with `out_valid=1` -> outputs go to reset values asynchronously, before the next edge. Next contention grants A first.
